bm_mem: RTL
===========

Name: bm_mem

Overview:
- Bitmatrix column store that sits directly downstream of the bitmatrix memory controller's read-request port and upstream of its read-data port.
- Holds up to M_MAX bitmatrix columns of BM_COL_W bits each.
- The host loads columns through a narrow word stream, which is packed into a full-width column.
- The controller reads whole columns with a fixed, pipelined read latency.

Parameters:
- K_MAX, 128, max data disks; sets column width.
- M_MAX, 128, max parity disks; sets memory depth (columns).
- W, 4, Galois-field word width.
- BM_COL_W, W*W*K_MAX, column width in bits (2048 by default).
- BM_MEM_ADDR_W, $clog2(M_MAX), column address width.
- HOST_W, 32, host load word width; BM_COL_W must be a multiple of HOST_W.
- WORDS_PER_COL, BM_COL_W/HOST_W, host words per column (64 by default).
- RD_LAT, 2, read latency in cycles from accepted request to data valid; legal range 1..4.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- host_bm_wr_val  in  1  host load word valid.
- host_bm_wr_data  in  HOST_W  host load word; word 0 maps to column bits [HOST_W-1:0].
- host_bm_wr_col_addr  in  BM_MEM_ADDR_W  target column; sampled on the first word of a column only.
- bm_mem_host_wr_rdy  out  1  block accepts a host word this cycle.
- bm_mem_host_wr_done  out  1  one-cycle pulse when a full column is committed.
- bm_mem_host_addr_err  out  1  sticky flag: a column load targeted an address >= M_MAX.
- bm_cntl_bm_mem_rd_rq  in  1  column read request.
- bm_cntl_bm_mem_rd_addr  in  BM_MEM_ADDR_W  column to read.
- bm_mem_bm_cntl_rd_data  out  BM_COL_W  read column.
- bm_mem_bm_cntl_rd_data_val  out  1  one-cycle valid for rd_data.

Behaviour:
- Reset values:
  - rdy=1, done=0, addr_err=0, rd_data_val=0, rd_data=0.
  - Word counter = 0; load FSM in IDLE; read pipeline cleared.
  - Array contents are not reset. Readback before a column is loaded is undefined, and the bench must not check it.
- Load FSM states: IDLE, FILL, COMMIT.
  - IDLE: on val&rdy, latch col_addr, store word 0 in the packing register, count=1, go to FILL.
  - FILL: each val&rdy stores the word at bits [count*HOST_W +: HOST_W] and increments count. When the word at count = WORDS_PER_COL-1 is accepted, go to COMMIT. val low holds state with no timeout.
  - COMMIT: rdy=0. Write the packing register to array[latched addr] in the first cycle with no read request, pulse done in that same cycle, count=0, go to IDLE.
  - If the latched addr >= M_MAX: skip the array write, set addr_err (cleared only by rstn), still pulse done and return to IDLE.
- Read path:
  - A read is accepted every cycle rd_rq=1. There is no backpressure and reads are never dropped.
  - Array read happens in the request cycle. The result is delayed through RD_LAT-1 register stages, so rd_data_val is asserted exactly RD_LAT cycles after rd_rq and rd_data is valid in that same cycle.
  - rd_data holds its last value while rd_data_val=0.
  - Back-to-back requests give back-to-back valid data in request order; throughput is 1 column/clock.
  - Out-of-range read address (>= M_MAX): returns all-zero data, still with valid.
- Arbitration: read has priority over COMMIT. A COMMIT cycle that coincides with rd_rq stalls one cycle; done is delayed accordingly.
- Write-then-read hazard: a read of the column being committed in the same cycle is impossible, because read wins. A read one cycle after done returns the new data.
- rstn asserted mid-load or mid-read: the partial column is discarded and in-flight read valids are dropped. The array keeps its old contents.

Test Plan:
- Load col 3 with 64 words, word i = 32'hA5A50000+i, val held high → rdy high for 64 cycles then low for 1; done pulses 1 cycle after the last word. Read addr 3 → val exactly 2 cycles later, data bits [31:0]=A5A50000 and [2047:2016]=A5A5003F.
- Load cols 0..3 with distinct patterns; issue reads 0,1,2,3 on consecutive cycles → 4 consecutive valid cycles starting at cycle +2, data in order.
- Hold rd_rq high while a column reaches COMMIT → commit stalls (rdy stays 0, no done) until rd_rq drops; done appears in the first cycle rd_rq=0; readback is correct.
- Load to col_addr=M_MAX (narrow the config so the address width permits it, e.g. M_MAX=100) → done pulses, addr_err goes to 1 and stays; col 0 is not corrupted.
- Gap the host stream with val=0 for 5 cycles mid-column → packing is unchanged and the final column is correct; col_addr changes during the gap are ignored.
- Assert rstn low after 20 words are loaded, with 2 reads in flight → no rd_data_val after reset and addr_err=0. A fresh 64-word load commits correctly, and a previously loaded column still reads intact.

Source files
------------

// File: rtl/bm_mem.sv
// Bitmatrix column store: packs host words into full columns and
// serves whole-column reads to the controller with a fixed latency.
module bm_mem #(
    parameter int K_MAX         = 128,
    parameter int M_MAX         = 128,
    parameter int W             = 4,
    parameter int BM_COL_W      = W * W * K_MAX,
    parameter int BM_MEM_ADDR_W = $clog2(M_MAX),
    parameter int HOST_W        = 32,
    parameter int WORDS_PER_COL = BM_COL_W / HOST_W,
    parameter int RD_LAT        = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     host_bm_wr_val,
    input  logic [HOST_W-1:0]        host_bm_wr_data,
    input  logic [BM_MEM_ADDR_W-1:0] host_bm_wr_col_addr,
    output logic                     bm_mem_host_wr_rdy,
    output logic                     bm_mem_host_wr_done,
    output logic                     bm_mem_host_addr_err,
    input  logic                     bm_cntl_bm_mem_rd_rq,
    input  logic [BM_MEM_ADDR_W-1:0] bm_cntl_bm_mem_rd_addr,
    output logic [BM_COL_W-1:0]      bm_mem_bm_cntl_rd_data,
    output logic                     bm_mem_bm_cntl_rd_data_val
);

    localparam int CNT_W = $clog2(WORDS_PER_COL + 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        COMMIT
    } state_t;

    state_t                     state;
    state_t                     state_nx;
    logic [CNT_W-1:0]           cnt;
    logic [BM_MEM_ADDR_W-1:0]   wr_addr;
    logic [BM_COL_W-1:0]        pack;
    logic [BM_COL_W-1:0]        mem [M_MAX];
    logic                       acc;
    logic                       last;
    logic                       wr_en;
    logic                       wr_ok;
    logic                       rd_ok;
    logic [BM_COL_W-1:0]        pd [RD_LAT];
    logic [RD_LAT-1:0]          pv;

    assign acc   = host_bm_wr_val && bm_mem_host_wr_rdy;
    assign last  = cnt == CNT_W'(WORDS_PER_COL - 1);
    assign wr_ok = 32'(wr_addr) < 32'(M_MAX);
    assign rd_ok = 32'(bm_cntl_bm_mem_rd_addr) < 32'(M_MAX);

    // Reads own the array port; a pending commit simply waits.
    always_comb begin
        state_nx            = state;
        bm_mem_host_wr_rdy  = 1'b1;
        bm_mem_host_wr_done = 1'b0;
        wr_en               = 1'b0;
        unique case (state)
            IDLE: begin
                if (host_bm_wr_val)
                    state_nx = (WORDS_PER_COL == 1) ? COMMIT : FILL;
            end
            FILL: begin
                if (host_bm_wr_val && last)
                    state_nx = COMMIT;
            end
            COMMIT: begin
                bm_mem_host_wr_rdy = 1'b0;
                if (!bm_cntl_bm_mem_rd_rq) begin
                    bm_mem_host_wr_done = 1'b1;
                    wr_en               = wr_ok;
                    state_nx            = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state                <= IDLE;
            cnt                  <= '0;
            wr_addr              <= '0;
            bm_mem_host_addr_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (bm_mem_host_wr_done)
                cnt <= '0;
            else if (acc)
                cnt <= cnt + CNT_W'(1);
            if (acc && state == IDLE)
                wr_addr <= host_bm_wr_col_addr;
            if (bm_mem_host_wr_done && !wr_ok)
                bm_mem_host_addr_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (acc)
            pack[int'(cnt) * HOST_W +: HOST_W] <= host_bm_wr_data;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= pack;
    end

    // Each stage only advances on a valid, so the last one holds its data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pv <= '0;
            for (int i = 0; i < RD_LAT; i++)
                pd[i] <= '0;
        end else begin
            pv[0] <= bm_cntl_bm_mem_rd_rq;
            if (bm_cntl_bm_mem_rd_rq)
                pd[0] <= rd_ok ? mem[bm_cntl_bm_mem_rd_addr] : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                if (pv[i-1])
                    pd[i] <= pd[i-1];
            end
        end
    end

    assign bm_mem_bm_cntl_rd_data     = pd[RD_LAT-1];
    assign bm_mem_bm_cntl_rd_data_val = pv[RD_LAT-1];

endmodule
